// File: rtl/mem256_rr_arbiter.sv
// Round-robin sequencer that serialises two requesters onto one 256-word memory port.
// One access in flight at a time; read data is returned to the owner with a one-cycle valid.
module mem256_rr_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [DATA_W-1:0] mem_write_in,
  input  logic [DATA_W-1:0] mem_read_out,
  output logic              busy
);

  typedef enum logic {IDLE, ACC} state_e;

  state_e      state_q;
  logic        ptr_q;   // 0: A has priority on a tie, 1: B
  logic        own_q;   // requester that owns the access in flight
  logic [3:0]  cnt_q;

  logic              win_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign win_b     = b_req & (~a_req | ptr_q);
  assign sel_we    = win_b ? b_we    : a_we;
  assign sel_addr  = win_b ? b_addr  : a_addr;
  assign sel_wdata = win_b ? b_wdata : a_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      own_q        <= 1'b0;
      cnt_q        <= '0;
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      mem_addr     <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_in <= '0;
      busy         <= 1'b0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req | b_req) begin
            mem_addr     <= sel_addr;
            mem_write_in <= sel_wdata;
            mem_write_en <= sel_we;
            mem_read_en  <= ~sel_we;
            a_gnt        <= ~win_b;
            b_gnt        <= win_b;
            ptr_q        <= ~win_b;
            own_q        <= win_b;
            cnt_q        <= 4'(WAIT_CYCLES);
            busy         <= 1'b1;
            state_q      <= ACC;
          end
        end
        ACC: begin
          if (cnt_q == 4'd0) begin
            // Memory read is combinational, so the data is valid on this edge.
            if (mem_read_en) begin
              if (own_q) begin
                b_rdata  <= mem_read_out;
                b_rvalid <= 1'b1;
              end else begin
                a_rdata  <= mem_read_out;
                a_rvalid <= 1'b1;
              end
            end
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            busy         <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem256_rr_arbiter.sv
// Directed bench: default instance (WAIT_CYCLES=0) and a WAIT_CYCLES=3 instance, each on its own memory model.
module tb_mem256_rr_arbiter;

  logic clk, rst;

  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] mem_addr, mem_write_in, mem_read_out;
  logic       mem_write_en, mem_read_en, busy;

  logic       w_a_req, w_a_we, w_b_req, w_b_we;
  logic [7:0] w_a_addr, w_a_wdata, w_b_addr, w_b_wdata;
  logic       w_a_gnt, w_a_rvalid, w_b_gnt, w_b_rvalid;
  logic [7:0] w_a_rdata, w_b_rdata;
  logic [7:0] w_mem_addr, w_mem_write_in, w_mem_read_out;
  logic       w_mem_write_en, w_mem_read_en, w_busy;

  logic [7:0] mem   [256];
  logic [7:0] mem_w [256];

  int n_chk  = 0;
  int n_pass = 0;

  mem256_rr_arbiter u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_write_in(mem_write_in), .mem_read_out(mem_read_out), .busy(busy)
  );

  mem256_rr_arbiter #(.WAIT_CYCLES(3)) u_dut_w (
    .clk(clk), .rst(rst),
    .a_req(w_a_req), .a_we(w_a_we), .a_addr(w_a_addr), .a_wdata(w_a_wdata),
    .a_gnt(w_a_gnt), .a_rvalid(w_a_rvalid), .a_rdata(w_a_rdata),
    .b_req(w_b_req), .b_we(w_b_we), .b_addr(w_b_addr), .b_wdata(w_b_wdata),
    .b_gnt(w_b_gnt), .b_rvalid(w_b_rvalid), .b_rdata(w_b_rdata),
    .mem_addr(w_mem_addr), .mem_write_en(w_mem_write_en), .mem_read_en(w_mem_read_en),
    .mem_write_in(w_mem_write_in), .mem_read_out(w_mem_read_out), .busy(w_busy)
  );

  assign mem_read_out   = mem[mem_addr];
  assign w_mem_read_out = mem_w[w_mem_addr];

  always @(posedge clk) begin
    if (mem_write_en)   mem[mem_addr]     <= mem_write_in;
    if (w_mem_write_en) mem_w[w_mem_addr] <= w_mem_write_in;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write and read enables must never overlap on either instance.
  always @(negedge clk)
    chk("en_excl", {30'd0, w_mem_write_en & w_mem_read_en, mem_write_en & mem_read_en}, 32'd0);

  logic [8:1] exp_a_seq, exp_b_seq;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      mem_w[i] = 8'h00;
    end
    mem_w[8'h55] = 8'h99;
    rst = 1'b1;
    {a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata} = '0;
    {w_a_req, w_a_we, w_a_addr, w_a_wdata, w_b_req, w_b_we, w_b_addr, w_b_wdata} = '0;
    tick();
    tick();
    chk("rst_outs", {a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, mem_addr,
                     mem_write_en, mem_read_en} , 32'd0);
    chk("rst_outs2", {8'd0, mem_write_in, busy, w_busy, w_mem_read_en, w_b_gnt}, 32'd0);
    rst = 1'b0;
    tick();

    // A write 0x3C -> 0x10
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h3C;
    tick();
    chk("wr_gnt", {a_gnt, b_gnt, mem_write_en, mem_read_en, busy}, 32'b10101);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_data", mem_write_in, 32'h3C);
    a_req = 1'b0;
    tick();
    chk("wr_done", {a_gnt, mem_write_en, mem_read_en, a_rvalid, busy}, 32'd0);
    chk("wr_keep_addr", mem_addr, 32'h10);

    // A read 0x10
    a_req = 1'b1; a_we = 1'b0;
    tick();
    chk("rd_gnt", {a_gnt, mem_write_en, mem_read_en}, 32'b101);
    a_req = 1'b0;
    tick();
    chk("rd_valid", {a_rvalid, b_rvalid, mem_read_en}, 32'b100);
    chk("rd_data", a_rdata, 32'h3C);
    tick();
    chk("rd_pulse", {a_rvalid, b_rvalid}, 32'd0);
    chk("rd_hold", a_rdata, 32'h3C);

    // Both requesters continuously after a fresh reset: A,B,A,B
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'hA0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h40; b_wdata = 8'hB0;
    exp_a_seq = 8'b0001_0001;
    exp_b_seq = 8'b0100_0100;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("rr_a%0d", i), a_gnt, exp_a_seq[i]);
      chk($sformatf("rr_b%0d", i), b_gnt, exp_b_seq[i]);
      if (i == 7) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end

    // Lone B read of A's data, granted twice in a row
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    tick();
    chk("lone_b_gnt1", {a_gnt, b_gnt, mem_read_en}, 32'b011);
    tick();
    chk("lone_b_rv1", {b_rvalid, a_rvalid, b_gnt}, 32'b100);
    chk("lone_b_data", b_rdata, 32'hA0);
    tick();
    chk("lone_b_gnt2", {a_gnt, b_gnt}, 32'b01);
    b_req = 1'b0;
    tick();
    chk("lone_b_rv2", b_rvalid, 32'd1);

    // A reads back B's write
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40;
    tick();
    chk("a_rd40_gnt", a_gnt, 32'd1);
    a_req = 1'b0;
    tick();
    chk("a_rd40_rv", {a_rvalid, b_rvalid}, 32'b10);
    chk("a_rd40_data", a_rdata, 32'hB0);
    chk("b_data_hold", b_rdata, 32'hA0);

    // WAIT_CYCLES=3: B read holds enable for 4 cycles
    w_b_req = 1'b1; w_b_we = 1'b0; w_b_addr = 8'h55;
    tick();
    chk("w_gnt", {w_b_gnt, w_mem_read_en, w_busy}, 32'b111);
    w_b_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("w_hold%0d", i), {w_b_gnt, w_mem_read_en, w_busy, w_b_rvalid}, 32'b0110);
    end
    tick();
    chk("w_done", {w_mem_read_en, w_busy, w_b_rvalid}, 32'b001);
    chk("w_data", w_b_rdata, 32'h99);
    tick();
    chk("w_rv_pulse", w_b_rvalid, 32'd0);

    // Reset in the middle of an A read on the WAIT instance
    w_a_req = 1'b1; w_a_we = 1'b0; w_a_addr = 8'h55;
    tick();
    chk("ab_gnt", {w_a_gnt, w_mem_read_en}, 32'b11);
    w_a_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("ab_rst", {w_mem_read_en, w_mem_write_en, w_a_gnt, w_a_rvalid, w_busy}, 32'd0);
    tick();
    chk("ab_no_rv", {w_a_rvalid, w_a_rdata}, 32'd0);
    rst = 1'b0;
    w_a_req = 1'b1; w_b_req = 1'b1; w_a_we = 1'b0; w_b_we = 1'b0;
    tick();
    chk("ab_ptr_a", {w_a_gnt, w_b_gnt}, 32'b10);
    w_a_req = 1'b0; w_b_req = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
